// File: rtl/mm_pkg.sv
// Shared types and sizing for the matrix-multiply datapath.
// The loader and the multiply core both import this package.
package mm_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int MAT_DIM_WIDTH = 6;
    localparam int MAT_DIM_SIZE  = 2**MAT_DIM_WIDTH;
    localparam int ADDR_WIDTH    = MAT_DIM_WIDTH*2;
    localparam int MAT_SIZE      = 2**ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [1:0] {
        S_LOAD_X = 2'd0,
        S_LOAD_Y = 2'd1,
        S_START  = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

endpackage

// File: rtl/mat_loader.sv
// Streams one X matrix then one Y matrix into their BRAMs, kicks the
// multiply core, and waits for it to finish before taking the next pair.
module mat_loader #(
    parameter int DATA_WIDTH    = mm_pkg::DATA_WIDTH,
    parameter int MAT_DIM_WIDTH = mm_pkg::MAT_DIM_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           in_ready,
    output logic                           x_we,
    output logic [MAT_DIM_WIDTH*2-1:0]     x_addr,
    output logic [DATA_WIDTH-1:0]          x_w_data,
    output logic                           y_we,
    output logic [MAT_DIM_WIDTH*2-1:0]     y_addr,
    output logic [DATA_WIDTH-1:0]          y_w_data,
    output logic                           mm_strt,
    input  logic                           mm_done,
    output logic                           busy,
    output logic [15:0]                    pair_cnt
);

    localparam int ADDR_WIDTH = MAT_DIM_WIDTH*2;
    localparam int MAT_SIZE   = 2**ADDR_WIDTH;

    import mm_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAT_SIZE-1);

    state_t                  r_state,    w_state;
    logic [ADDR_WIDTH-1:0]   r_cnt,      w_cnt;
    logic                    r_in_ready, w_in_ready;
    logic                    r_x_we,     w_x_we;
    logic [ADDR_WIDTH-1:0]   r_x_addr,   w_x_addr;
    logic [DATA_WIDTH-1:0]   r_x_w_data, w_x_w_data;
    logic                    r_y_we,     w_y_we;
    logic [ADDR_WIDTH-1:0]   r_y_addr,   w_y_addr;
    logic [DATA_WIDTH-1:0]   r_y_w_data, w_y_w_data;
    logic                    r_mm_strt,  w_mm_strt;
    logic                    r_busy,     w_busy;
    logic [15:0]             r_pair_cnt, w_pair_cnt;
    logic                    w_xfer;

    assign w_xfer   = in_valid && r_in_ready;

    assign in_ready = r_in_ready;
    assign x_we     = r_x_we;
    assign x_addr   = r_x_addr;
    assign x_w_data = r_x_w_data;
    assign y_we     = r_y_we;
    assign y_addr   = r_y_addr;
    assign y_w_data = r_y_w_data;
    assign mm_strt  = r_mm_strt;
    assign busy     = r_busy;
    assign pair_cnt = r_pair_cnt;

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_in_ready = r_in_ready;
        w_x_we     = 1'b0;
        w_x_addr   = r_x_addr;
        w_x_w_data = '0;
        w_y_we     = 1'b0;
        w_y_addr   = r_y_addr;
        w_y_w_data = '0;
        w_mm_strt  = 1'b0;
        w_busy     = r_busy;
        w_pair_cnt = r_pair_cnt;

        case (r_state)
            S_LOAD_X: begin
                w_in_ready = 1'b1;
                if (w_xfer) begin
                    w_x_we     = 1'b1;
                    w_x_addr   = r_cnt;
                    w_x_w_data = in_data;
                    if (r_cnt == LAST_ADDR) begin
                        w_cnt   = '0;
                        w_state = S_LOAD_Y;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end
            S_LOAD_Y: begin
                w_in_ready = 1'b1;
                if (w_xfer) begin
                    w_y_we     = 1'b1;
                    w_y_addr   = r_cnt;
                    w_y_w_data = in_data;
                    if (r_cnt == LAST_ADDR) begin
                        // Stop accepting on the same edge the last Y word lands.
                        w_cnt      = '0;
                        w_in_ready = 1'b0;
                        w_state    = S_START;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end
            S_START: begin
                w_in_ready = 1'b0;
                w_mm_strt  = 1'b1;
                w_busy     = 1'b1;
                w_state    = S_WAIT;
            end
            S_WAIT: begin
                w_in_ready = 1'b0;
                // A done coincident with our own start pulse cannot belong to this pair.
                if (mm_done && !r_mm_strt) begin
                    w_busy     = 1'b0;
                    w_pair_cnt = r_pair_cnt + 16'd1;
                    w_in_ready = 1'b1;
                    w_state    = S_LOAD_X;
                end
            end
            default: begin
                w_state    = S_LOAD_X;
                w_cnt      = '0;
                w_in_ready = 1'b0;
                w_x_w_data = 'x;
                w_y_w_data = 'x;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_LOAD_X;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_x_we     <= 1'b0;
            r_x_addr   <= '0;
            r_x_w_data <= '0;
            r_y_we     <= 1'b0;
            r_y_addr   <= '0;
            r_y_w_data <= '0;
            r_mm_strt  <= 1'b0;
            r_busy     <= 1'b0;
            r_pair_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_in_ready <= w_in_ready;
            r_x_we     <= w_x_we;
            r_x_addr   <= w_x_addr;
            r_x_w_data <= w_x_w_data;
            r_y_we     <= w_y_we;
            r_y_addr   <= w_y_addr;
            r_y_w_data <= w_y_w_data;
            r_mm_strt  <= w_mm_strt;
            r_busy     <= w_busy;
            r_pair_cnt <= w_pair_cnt;
        end
    end

endmodule

// File: tb/tb_mat_loader.sv
// Bench for mat_loader on 2x2 matrices: directed table, corner sequences,
// and random traffic checked every cycle against a word-counting model.
module tb_mat_loader;

    localparam int DW  = 32;
    localparam int MDW = 1;
    localparam int AW  = MDW*2;
    localparam int MS  = 2**AW;
    localparam int VW  = 1 + 1 + AW + DW + 1 + AW + DW + 1 + 1 + 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          mm_done = 1'b0;
    logic          in_ready, x_we, y_we, mm_strt, busy;
    logic [AW-1:0] x_addr, y_addr;
    logic [DW-1:0] x_w_data, y_w_data;
    logic [15:0]   pair_cnt;

    int n_vec = 0;
    int n_err = 0;
    int n_strt = 0;
    int n_wr = 0;

    mat_loader #(.DATA_WIDTH(DW), .MAT_DIM_WIDTH(MDW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .x_we(x_we), .x_addr(x_addr), .x_w_data(x_w_data),
        .y_we(y_we), .y_addr(y_addr), .y_w_data(y_w_data), .mm_strt(mm_strt),
        .mm_done(mm_done), .busy(busy), .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    // Model: a pair is 2*MS accepted words; the first MS go to X, the rest to Y.
    int            m_taken;
    int            m_phase;   // 0 loading, 1 start due, 2 waiting for done
    logic          m_ready, m_xwe, m_ywe, m_strt, m_busy;
    logic [AW-1:0] m_xaddr, m_yaddr;
    logic [DW-1:0] m_xdata, m_ydata;
    logic [15:0]   m_pairs;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_taken <= 0; m_phase <= 0; m_ready <= 1'b0;
            m_xwe <= 1'b0; m_xaddr <= '0; m_xdata <= '0;
            m_ywe <= 1'b0; m_yaddr <= '0; m_ydata <= '0;
            m_strt <= 1'b0; m_busy <= 1'b0; m_pairs <= '0;
        end else begin
            m_xwe <= 1'b0; m_ywe <= 1'b0; m_xdata <= '0; m_ydata <= '0; m_strt <= 1'b0;
            if (m_phase == 0) begin
                m_ready <= 1'b1;
                if (in_valid && m_ready) begin
                    if (m_taken < MS) begin
                        m_xwe <= 1'b1; m_xaddr <= AW'(m_taken); m_xdata <= in_data;
                    end else begin
                        m_ywe <= 1'b1; m_yaddr <= AW'(m_taken - MS); m_ydata <= in_data;
                    end
                    if (m_taken == 2*MS-1) begin
                        m_taken <= 0; m_phase <= 1; m_ready <= 1'b0;
                    end else begin
                        m_taken <= m_taken + 1;
                    end
                end
            end else if (m_phase == 1) begin
                m_strt <= 1'b1; m_busy <= 1'b1; m_phase <= 2;
            end else if (mm_done && !m_strt) begin
                m_busy <= 1'b0; m_pairs <= m_pairs + 16'd1; m_ready <= 1'b1; m_phase <= 0;
            end
        end
    end

    function automatic logic [VW-1:0] pack(input logic rdy, input logic xwe, input logic [AW-1:0] xa,
                                           input logic [DW-1:0] xd, input logic ywe, input logic [AW-1:0] ya,
                                           input logic [DW-1:0] yd, input logic st, input logic bz,
                                           input logic [15:0] pc);
        return {rdy, xwe, xa, xd, ywe, ya, yd, st, bz, pc};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return pack(in_ready, x_we, x_addr, x_w_data, y_we, y_addr, y_w_data, mm_strt, busy, pair_cnt);
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return pack(m_ready, m_xwe, m_xaddr, m_xdata, m_ywe, m_yaddr, m_ydata, m_strt, m_busy, m_pairs);
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic dn);
        in_valid = v; in_data = d; mm_done = dn;
        @(posedge clk); #1;
        check("cycle", dut_vec(), model_vec());
        if (mm_strt) n_strt++;
        n_wr += int'(x_we) + int'(y_we);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; mm_done = 1'b0; in_data = '0;
        rst = 1'b0;
        #1;
        check("async_rst", dut_vec(), '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_start();
        for (int t = 0; t < 6 && !mm_strt; t++) step(1'b0, '0, 1'b0);
        check("start_seen", VW'(mm_strt), VW'(1));
    endtask

    typedef struct {
        logic          vld;
        logic [DW-1:0] data;
        logic          done;
        logic [VW-1:0] exp;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int base_s, base_w;
        logic          v;
        logic [DW-1:0] d;
        logic          dn;

        // Continuous stream 1..8 from reset: X 1..4, Y 5..8, then one start.
        tbl[0] = '{1'b0, 32'd0, 1'b0, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        for (int k = 1; k <= 4; k++)
            tbl[k] = '{1'b1, DW'(k), 1'b0, pack(1, 1, AW'(k-1), DW'(k), 0, 0, 0, 0, 0, 0)};
        for (int k = 5; k <= 7; k++)
            tbl[k] = '{1'b1, DW'(k), 1'b0, pack(1, 0, 2'd3, 0, 1, AW'(k-5), DW'(k), 0, 0, 0)};
        tbl[8]  = '{1'b1, 32'd8,  1'b0, pack(0, 0, 2'd3, 0, 1, 2'd3, 32'd8, 0, 0, 0)};
        tbl[9]  = '{1'b1, 32'd99, 1'b0, pack(0, 0, 2'd3, 0, 0, 2'd3, 0, 1, 1, 0)};
        tbl[10] = '{1'b1, 32'd99, 1'b0, pack(0, 0, 2'd3, 0, 0, 2'd3, 0, 0, 1, 0)};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].vld, tbl[i].data, tbl[i].done);
            check("table", dut_vec(), tbl[i].exp);
        end

        // Long wait for done with valid held high: nothing may be accepted.
        base_w = n_wr;
        repeat (20) step(1'b1, 32'd99, 1'b0);
        check("wait_no_write", VW'(n_wr - base_w), '0);
        check("wait_ready", VW'(in_ready), '0);

        step(1'b1, 32'd11, 1'b1);
        check("done_rearm", VW'({busy, pair_cnt, in_ready}), VW'({1'b0, 16'd1, 1'b1}));
        step(1'b1, 32'd11, 1'b0);
        check("rearm_x0", VW'({x_we, x_addr, x_w_data}), VW'({1'b1, 2'd0, 32'd11}));
        step(1'b1, 32'd12, 1'b0);
        step(1'b0, 32'd0, 1'b1);
        check("done_in_load", VW'({pair_cnt, x_we}), VW'({16'd1, 1'b0}));
        step(1'b1, 32'd13, 1'b0);
        check("load_resume_x2", VW'({x_we, x_addr, x_w_data}), VW'({1'b1, 2'd2, 32'd13}));
        step(1'b1, 32'd14, 1'b0);
        step(1'b1, 32'd15, 1'b0);
        check("y0_before_rst", VW'({y_we, y_addr, y_w_data}), VW'({1'b1, 2'd0, 32'd15}));

        // Reset mid-Y: the next stream starts at X addr0 with a single start.
        do_reset();
        step(1'b0, '0, 1'b0);
        base_s = n_strt;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, DW'(k), 1'b0);
            if (k == 1) check("rst_restart_x0", VW'({x_we, x_addr, x_w_data}), VW'({1'b1, 2'd0, 32'd1}));
        end
        repeat (4) step(1'b0, '0, 1'b0);
        check("one_start", VW'(n_strt - base_s), VW'(1));
        step(1'b0, '0, 1'b1);
        check("pair_after_rst", VW'(pair_cnt), VW'(1));

        // Three back-to-back pairs, done three cycles after each start.
        do_reset();
        step(1'b0, '0, 1'b0);
        base_s = n_strt;
        base_w = n_wr;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 8; k++) step(1'b1, $urandom, 1'b0);
            wait_start();
            repeat (2) step(1'b0, '0, 1'b0);
            step(1'b0, '0, 1'b1);
        end
        check("b2b_pairs", VW'(pair_cnt), VW'(3));
        check("b2b_starts", VW'(n_strt - base_s), VW'(3));
        check("b2b_writes", VW'(n_wr - base_w), VW'(24));

        // Random traffic: gaps, stray done pulses, occasional reset.
        v = 1'b0; d = '0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            if (!(in_valid && !in_ready)) begin
                v = ($urandom_range(0, 3) != 0);
                d = $urandom;
            end
            dn = ($urandom_range(0, 7) == 0) && !mm_strt;
            step(v, d, dn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mat_loader.md
Name: mat_loader

Overview:
- Upstream stage of the matrix-multiply core.
- Accepts a valid/ready stream of matrix elements and writes the first MAT_SIZE words into the X BRAM, row-major.
- Writes the next MAT_SIZE words into the Y BRAM, row-major.
- Then pulses the core's start, waits for its done, and re-arms for the next matrix pair.

Parameters:
- DATA_WIDTH, 32: element width.
- MAT_DIM_WIDTH, 6: log2 of matrix dimension.
- MAT_DIM_SIZE, 2**MAT_DIM_WIDTH: rows/cols per matrix.
- ADDR_WIDTH, MAT_DIM_WIDTH*2: BRAM address width.
- MAT_SIZE, 2**ADDR_WIDTH: elements per matrix.

Ports:
- clk, in, 1: clock; all logic on rising edge.
- rst, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: stream element valid.
- in_data, in, DATA_WIDTH: stream element.
- in_ready, out, 1: loader can accept an element.
- x_we, out, 1: X BRAM write enable.
- x_addr, out, ADDR_WIDTH: X BRAM write address.
- x_w_data, out, DATA_WIDTH: X BRAM write data.
- y_we, out, 1: Y BRAM write enable.
- y_addr, out, ADDR_WIDTH: Y BRAM write address.
- y_w_data, out, DATA_WIDTH: Y BRAM write data.
- mm_strt, out, 1: one-cycle start pulse to the multiply core.
- mm_done, in, 1: completion pulse from the multiply core.
- busy, out, 1: high from start pulse until done observed.
- pair_cnt, out, 16: number of completed matrix pairs, wraps at 2**16.

Behaviour:
- Reset (rst low, async): state S_LOAD_X, element counter 0, pair_cnt 0. All outputs 0, except in_ready, which is 0 during reset and goes 1 on the first clock edge after rst deasserts.
- All outputs are registered.
- Handshake: a transfer occurs on a rising edge where in_valid && in_ready.
  - in_data must be held while in_valid && !in_ready.
  - The loader never drops an accepted word.
- States:
  - S_LOAD_X:
    - in_ready=1.
    - Each transfer registers x_we=1, x_addr=cnt, x_w_data=in_data on that edge, so it is visible the cycle after the transfer (latency 1).
    - cnt increments.
    - On the transfer with cnt==MAT_SIZE-1: cnt wraps to 0, go to S_LOAD_Y.
  - S_LOAD_Y:
    - Identical behaviour, using the y_* outputs.
    - On the final transfer: go to S_START, and in_ready drops to 0 on that same edge.
  - S_START:
    - in_ready=0, mm_strt=1 for exactly one cycle, busy=1.
    - Next state S_WAIT.
    - The last Y write has already been presented to the BRAM in the cycle mm_strt is high, so the core sees complete data.
  - S_WAIT:
    - in_ready=0, busy=1.
    - When mm_done==1: busy=0 next cycle, pair_cnt+1, in_ready=1 next cycle, go to S_LOAD_X.
  - Illegal state: go to S_LOAD_X; data outputs X in simulation.
- Write outputs default:
  - x_we and y_we are 0 in every cycle without a corresponding transfer.
  - x_addr/y_addr hold their last value when not writing.
  - x_w_data/y_w_data are 0 when not writing.
- in_valid low mid-matrix: no write, cnt holds, state holds.
- Gaps of any length are allowed.
- mm_done outside S_WAIT: ignored, no count change.
- mm_done in the same cycle as the S_START pulse: cannot occur; ignored.
- Counter width is ADDR_WIDTH; the wrap from MAT_SIZE-1 to 0 is via the explicit compare, not overflow reliance.
- Reset mid-load: partially written BRAM contents are abandoned. The next stream restarts at X address 0. No mm_strt is emitted for a partial pair.
- Reset in S_WAIT: busy=0 immediately (async). The core is reset by the same rst.
- in_ready is never high in S_START/S_WAIT. No word is accepted between the last Y element and mm_done.

Decomposition:
- Shared package mm_pkg:
  - data_t and addr_t typedefs.
  - DATA_WIDTH, MAT_DIM_WIDTH, MAT_DIM_SIZE, ADDR_WIDTH and MAT_SIZE constants.
  - The loader state_t enum (S_LOAD_X, S_LOAD_Y, S_START, S_WAIT).
  - The multiply core's state_t stays local to the core.
- No sub-module is needed.
- The design is one state-register always_ff plus one next-state/output always_comb. A single shared element counter serves both X and Y.

Test Plan:
- MAT_DIM_WIDTH=1 (2x2). Stream 1..8 continuously with in_valid=1:
  - X writes addr0..3 = 1,2,3,4.
  - Y writes addr0..3 = 5,6,7,8.
  - in_ready falls after the 8th transfer.
  - mm_strt pulses exactly once, 1 cycle after the last Y write is visible.
  - busy=1.
- Same stream with in_valid toggled 1-0-1-0: writes occur only on transfer cycles. Addresses stay contiguous 0..3 per matrix with no duplicates or skips.
- Hold mm_done=0 for 20 cycles after the start pulse, with in_valid=1 and in_data=99: in_ready=0 throughout, no x_we/y_we. Pulse mm_done: the next cycle busy=0, pair_cnt=1, in_ready=1, and the next word writes X addr0.
- Pulse mm_done during S_LOAD_X after 2 words: pair_cnt unchanged, load continues at X addr2.
- Assert rst low after 5 words (X full, Y addr0 written):
  - All outputs 0 asynchronously.
  - After release, stream 1..8 again: writes restart at X addr0, and exactly one mm_strt occurs.
- Run 3 back-to-back pairs, with mm_done returned 3 cycles after each mm_strt: pair_cnt=3, 3 start pulses, 24 writes total.
